// File: rtl/accum_table_rd_seq.sv
// Read sequencer for the accumulator table: walks submatrix rows per column
// tile and issues per-channel reads, optionally skewed one cycle per channel.
// Parameters: MAX_OUT_ROWS, MAX_OUT_COLS, SYS_ARR_ROWS, SYS_ARR_COLS.
// Ports: clk, reset (sync, active-high), start, num_submats_m/n, out_ready,
//   rd_en[SYS_ARR_COLS], rd_addr[SYS_ARR_COLS*ADDR_W], busy, done.
// Build option: define ACCUM_RD_SKEW_EN to skew channel c by c cycles.
module accum_table_rd_seq #(
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  localparam int NSM = MAX_OUT_ROWS / SYS_ARR_ROWS,
  localparam int NSN = MAX_OUT_COLS / SYS_ARR_COLS,
  localparam int ADDR_W = $clog2(MAX_OUT_ROWS * NSN),
  localparam int MW = $clog2(NSM + 1),
  localparam int NW = $clog2(NSN + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [MW-1:0]                    num_submats_m,
  input  logic [NW-1:0]                    num_submats_n,
  input  logic                             out_ready,
  output logic [SYS_ARR_COLS-1:0]          rd_en,
  output logic [SYS_ARR_COLS*ADDR_W-1:0]   rd_addr,
  output logic                             busy,
  output logic                             done
);

  localparam int RW = (SYS_ARR_ROWS > 1) ? $clog2(SYS_ARR_ROWS) : 1;
  localparam int DW = (SYS_ARR_COLS > 1) ? $clog2(SYS_ARR_COLS) : 1;
  localparam int DRAIN_LAST = (SYS_ARR_COLS > 1) ? SYS_ARR_COLS - 2 : 0;

`ifdef ACCUM_RD_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif
  localparam bit HAS_DRAIN = SKEW && (SYS_ARR_COLS > 1);
  localparam int LANES = SKEW ? SYS_ARR_COLS : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [MW-1:0] cnt_m_q, m_q, m_nx, m_clamp;
  logic [NW-1:0] cnt_n_q, n_q, n_nx, n_clamp;
  logic [RW-1:0] r_q, r_nx;
  logic [DW-1:0] drain_q;
  logic [ADDR_W-1:0] addr_nx;
  logic zero_cnt;
  logic last_step;

  // Lane 0 is channel 0's output register; lanes 1.. are skew stages.
  logic [LANES-1:0] en_q;
  logic [ADDR_W-1:0] addr_q [LANES];

  always_comb begin
    m_clamp = (num_submats_m > MW'(NSM)) ? MW'(NSM) : num_submats_m;
    n_clamp = (num_submats_n > NW'(NSN)) ? NW'(NSN) : num_submats_n;
    zero_cnt = (m_clamp == '0) || (n_clamp == '0);
  end

  // Counters hold the step currently presented on channel 0.
  always_comb begin
    last_step = (r_q == RW'(SYS_ARR_ROWS - 1))
             && (m_q == cnt_m_q - 1'b1)
             && (n_q == cnt_n_q - 1'b1);
    r_nx = r_q + 1'b1;
    m_nx = m_q;
    n_nx = n_q;
    if (r_q == RW'(SYS_ARR_ROWS - 1)) begin
      r_nx = '0;
      if (m_q == cnt_m_q - 1'b1) begin
        m_nx = '0;
        n_nx = n_q + 1'b1;
      end else begin
        m_nx = m_q + 1'b1;
      end
    end
    addr_nx = ADDR_W'(n_nx) * ADDR_W'(MAX_OUT_ROWS)
            + ADDR_W'(m_nx) * ADDR_W'(SYS_ARR_ROWS)
            + ADDR_W'(r_nx);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start && out_ready)
          state_nxt = zero_cnt ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (out_ready && last_step)
          state_nxt = HAS_DRAIN ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        if (out_ready && drain_q == DW'(DRAIN_LAST))
          state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_m_q <= '0;
      cnt_n_q <= '0;
      r_q     <= '0;
      m_q     <= '0;
      n_q     <= '0;
      drain_q <= '0;
      en_q    <= '0;
      for (int c = 0; c < LANES; c++)
        addr_q[c] <= '0;
    end else if (out_ready) begin
      unique case (state)
        S_IDLE: begin
          if (start && !zero_cnt) begin
            cnt_m_q   <= m_clamp;
            cnt_n_q   <= n_clamp;
            r_q       <= '0;
            m_q       <= '0;
            n_q       <= '0;
            en_q[0]   <= 1'b1;
            addr_q[0] <= '0;
          end
        end
        S_RUN: begin
          if (last_step) begin
            en_q[0] <= 1'b0;
            drain_q <= '0;
          end else begin
            r_q       <= r_nx;
            m_q       <= m_nx;
            n_q       <= n_nx;
            en_q[0]   <= 1'b1;
            addr_q[0] <= addr_nx;
          end
        end
        S_DRAIN: drain_q <= drain_q + 1'b1;
        default: en_q[0] <= 1'b0;
      endcase
      // Skew stages only take a new address along with a valid.
      for (int c = 1; c < LANES; c++) begin
        en_q[c] <= en_q[c-1];
        if (en_q[c-1])
          addr_q[c] <= addr_q[c-1];
      end
    end
  end

  always_comb begin
    busy    = (state == S_RUN) || (state == S_DRAIN);
    done    = (state == S_DONE);
    rd_en   = '0;
    rd_addr = '0;
    for (int c = 0; c < SYS_ARR_COLS; c++) begin
      rd_en[c] = en_q[SKEW ? c : 0] & out_ready;
      rd_addr[c*ADDR_W +: ADDR_W] = addr_q[SKEW ? c : 0];
    end
  end

endmodule

// File: tb/tb_accum_table_rd_seq.sv
// Bench for accum_table_rd_seq: directed and random runs against a
// step-count model of channel timing, addresses, busy and done.
module tb_accum_table_rd_seq;

  localparam int MOR = 128;
  localparam int MOC = 128;
  localparam int SR = 16;
  localparam int SC = 16;
  localparam int NSM = MOR / SR;
  localparam int NSN = MOC / SC;
  localparam int AW = $clog2(MOR * NSN);
  localparam int MW = $clog2(NSM + 1);
  localparam int NW = $clog2(NSN + 1);

`ifdef ACCUM_RD_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b1;
  logic [MW-1:0] num_submats_m = '0;
  logic [NW-1:0] num_submats_n = '0;
  logic out_ready = 1'b1;
  logic [SC-1:0] rd_en;
  logic [SC*AW-1:0] rd_addr;
  logic busy;
  logic done;

  int checks = 0;
  int errors = 0;
  int last_addr [SC];

  accum_table_rd_seq #(
    .MAX_OUT_ROWS(MOR),
    .MAX_OUT_COLS(MOC),
    .SYS_ARR_ROWS(SR),
    .SYS_ARR_COLS(SC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_submats_m(num_submats_m),
    .num_submats_n(num_submats_n),
    .out_ready(out_ready),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Address of step s: n outer, m middle, row inner.
  function automatic int step_addr(input int s, input int cm);
    int r, m, n;
    r = s % SR;
    m = (s / SR) % cm;
    n = s / (SR * cm);
    return n * MOR + m * SR + r;
  endfunction

  function automatic logic [SC*AW-1:0] addr_bus();
    logic [SC*AW-1:0] b;
    b = '0;
    for (int c = 0; c < SC; c++)
      b[c*AW +: AW] = AW'(last_addr[c]);
    return b;
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_rd_en"}, rd_en, '0);
    chk({tag, "_rd_addr"}, rd_addr, addr_bus());
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic run(input int mi, input int ni, input int stall_pct,
                     input int abort_at);
    int cm, cn, T, fin, p, t, s;
    bit rdy, fin_seen;
    logic [SC-1:0] exp_en;
    cm = (mi > NSM) ? NSM : mi;
    cn = (ni > NSN) ? NSN : ni;
    T = cm * cn * SR;
    fin = (T == 0) ? 0 : T + (SKEW ? SC - 1 : 0);

    @(posedge clk); #1;
    start = 1'b1;
    num_submats_m = MW'(mi);
    num_submats_n = NW'(ni);
    out_ready = 1'b1;
    @(negedge clk);
    check_quiet("start_cycle");

    p = 0;
    t = 1;
    fin_seen = 1'b0;
    while (!fin_seen) begin
      @(posedge clk); #1;
      rdy = ($urandom_range(99) >= stall_pct);
      out_ready = rdy;
      start = 1'($urandom_range(1));
      num_submats_m = MW'($urandom_range(15));
      num_submats_n = NW'($urandom_range(15));
      if (t == abort_at) begin
        reset = 1'b1;
        start = 1'b1;
      end
      @(negedge clk);
      exp_en = '0;
      for (int c = 0; c < SC; c++) begin
        s = p - (SKEW ? c : 0);
        if (T > 0 && s >= 0 && s < T) begin
          exp_en[c] = rdy;
          last_addr[c] = step_addr(s, cm);
        end
      end
      chk("rd_en", rd_en, exp_en);
      chk("rd_addr", rd_addr, addr_bus());
      chk("busy", busy, (T > 0) && (p < fin));
      chk("done", done, p == fin);
      if (p == fin) fin_seen = 1'b1;
      if (rdy) p++;
      t++;
      if (abort_at > 0 && t > abort_at) break;
      if (t > 5000) begin
        chk("done_timeout", 1, 0);
        break;
      end
    end

    if (abort_at > 0) begin
      for (int c = 0; c < SC; c++)
        last_addr[c] = 0;
      for (int k = 0; k < 9; k++) begin
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        out_ready = 1'($urandom_range(1));
        @(negedge clk);
        check_quiet("after_abort");
      end
    end else begin
      @(posedge clk); #1;
      start = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check_quiet("post_done");
    end
  endtask

  initial begin
    for (int c = 0; c < SC; c++)
      last_addr[c] = 0;

    // Reset with start held high must leave everything idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("in_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_quiet("reset_release");
    @(posedge clk); #1;
    @(negedge clk);
    check_quiet("idle");

    run(1, 1, 0, 0);
    run(2, 2, 0, 0);
    run(0, 3, 0, 0);
    run(3, 0, 0, 0);
    run(1, 1, 0, 10);
    run(1, 1, 0, 0);
    run(1, 1, 30, 0);
    run(15, 1, 10, 0);
    run(1, 15, 10, 0);
    for (int i = 0; i < 5; i++)
      run($urandom_range(0, 15), $urandom_range(0, 4), 25, 0);
    run(2, 3, 20, 40);
    run(2, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum_table_rd_seq.md
ACCUM_TABLE_RD_SEQ -- requirements
Module: accum_table_rd_seq

Interface
REQ-001: MAX_OUT_ROWS, default 128, maximum output-matrix rows held in the accumulator table.
REQ-002: MAX_OUT_COLS, default 128, maximum output-matrix columns.
REQ-003: SYS_ARR_ROWS, default 16, systolic array rows (rows per submatrix).
REQ-004: SYS_ARR_COLS, default 16, systolic array columns (read channels).
REQ-005: Derived: NSM = MAX_OUT_ROWS/SYS_ARR_ROWS; NSN = MAX_OUT_COLS/SYS_ARR_COLS; ADDR_W = $clog2(MAX_OUT_ROWS*NSN).
REQ-006: One clock; reset is synchronous and active-high.
REQ-007: clk  input  1  clock; all state updates on rising edge.
REQ-008: reset  input  1  synchronous active-high reset.
REQ-009: start  input  1  begin sequence; sampled only in IDLE.
REQ-010: num_submats_m  input  $clog2(NSM+1)  submatrix rows to read.
REQ-011: num_submats_n  input  $clog2(NSN+1)  submatrix columns to read.
REQ-012: out_ready  input  1  downstream ready; low stalls the whole sequencer.
REQ-013: rd_en  output  SYS_ARR_COLS  per-channel read enable.
REQ-014: rd_addr  output  SYS_ARR_COLS*ADDR_W  channel c address at bits [c*ADDR_W +: ADDR_W].
REQ-015: busy  output  1  high from the cycle after an accepted start until done.
REQ-016: done  output  1  one-cycle completion pulse.

Function
REQ-017: FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN after last step issued on channel 0; DRAIN->DONE when the last valid leaves channel SYS_ARR_COLS-1; DONE->IDLE unconditionally next cycle.
REQ-018: num_submats_m/n latched at accepted start; values above NSM/NSN clamp to NSM/NSN; start outside IDLE ignored.
REQ-019: If either latched count is 0, FSM goes IDLE->DONE, no rd_en asserted, done pulses the cycle after start.
REQ-020: Step order: n outer (0..cnt_n-1), m middle (0..cnt_m-1), r inner (0..SYS_ARR_ROWS-1); T = cnt_m*cnt_n*SYS_ARR_ROWS steps.
REQ-021: Step address = n*MAX_OUT_ROWS + m*SYS_ARR_ROWS + r, computed in ADDR_W bits without overflow.
REQ-022: Channel 0 (registered) issues step k in the k-th non-stalled cycle after start; first rd_en[0] the cycle after start.
REQ-023: Channel c>0 registers channel c-1 rd_en/rd_addr (1-cycle skew per channel), per REQ-035.
REQ-024: out_ready low: counters, skew registers, FSM state frozen; rd_en forced 0 that cycle; resumes unchanged when high.
REQ-025: rd_addr holds last value when rd_en is 0.
REQ-026: With out_ready continuously high, done pulses exactly T+SYS_ARR_COLS cycles after start (skew on).

Reset
REQ-027: On reset: state IDLE, rd_en 0, rd_addr 0, busy 0, done 0, counters and skew registers 0.
REQ-028: Reset mid-operation aborts the sequence; no further rd_en until a new start, and no done pulse.
REQ-029: start asserted with reset is ignored.

Configuration
REQ-030: Macro ACCUM_RD_SKEW_EN compiles in the per-channel skew of REQ-023.
REQ-031: With ACCUM_RD_SKEW_EN defined: behaviour per REQ-023, DRAIN lasts SYS_ARR_COLS-1 non-stalled cycles.
REQ-032: Without it: all channels issue identical rd_en/rd_addr in the same cycle, DRAIN skipped, done pulses T+1 cycles after start.
REQ-033: Macro affects no port widths or reset values.

Verification (defaults, ACCUM_RD_SKEW_EN defined unless stated; start at cycle 0)
REQ-034: m=1,n=1, out_ready=1 -> rd_en[0] cycles 1..16 addr 0..15; rd_en[15] cycles 16..31 addr 0..15; done cycle 32.
REQ-035: m=2,n=2 -> channel 0 addr 0..31 then 128..159 (cycles 1..64); done cycle 80.
REQ-036: m=1,n=1, out_ready low cycles 5..7 -> rd_en all 0 cycles 5..7; channel 0 addr sequence unbroken, done cycle 35.
REQ-037: m=0,n=3 -> no rd_en ever; done pulse cycle 1; busy stays 0.
REQ-038: m=1,n=1, reset at cycle 10 -> all outputs 0 cycle 11 onward, no done; new start at 20 reproduces REQ-034 shifted by 20.
REQ-039: ACCUM_RD_SKEW_EN undefined, m=1,n=1 -> all 16 channels addr 0..15 cycles 1..16; done cycle 17.
